// File: rtl/ace_ccu_conflict_table.sv
// CAM-style table of cache lines with outstanding snoop-initiated transactions.
// Stalls conflicting snoops, merges hits in merge mode, and retires entries on completions.
module ace_ccu_conflict_table #(
  parameter int CmAddrWidth   = 8,
  parameter int NoRespPorts   = 4,
  parameter int MaxSnoopTrans = 8,
  parameter int MaxRespTrans  = 8,
  parameter bit Serialize     = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 cm_snoop_valid_i,
  input  logic                                 cm_snoop_ready_i,
  input  logic [CmAddrWidth-1:0]               cm_snoop_addr_i,
  output logic                                 cm_snoop_stall_o,
  input  logic [NoRespPorts-1:0]               cm_x_req_i,
  input  logic [NoRespPorts*CmAddrWidth-1:0]   cm_x_addr_i,
  output logic [$clog2(MaxSnoopTrans+1)-1:0]   occupancy_o,
  output logic                                 full_o,
  output logic                                 err_o
);

  localparam int CntW = $clog2(MaxRespTrans + 1);
  localparam int OccW = $clog2(MaxSnoopTrans + 1);
  localparam int DecW = $clog2(NoRespPorts + 1);
  localparam int SumW = ((CntW > DecW) ? CntW : DecW) + 1;

  typedef struct packed {
    logic                   valid;
    logic [CmAddrWidth-1:0] idx;
    logic [CntW-1:0]        cnt;
  } entry_t;

  entry_t [MaxSnoopTrans-1:0] tbl_q, tbl_d;
  logic   [OccW-1:0]          occ_q, occ_d;
  logic                       full_q, full_d;
  logic                       err_q, err_d;

  logic [MaxSnoopTrans-1:0] hit_vec, free_sel;
  logic [CntW-1:0]          hit_cnt;
  logic                     hit, all_valid, hit_block, fire, unmatched, over_dec;
  logic [DecW-1:0]          dec [MaxSnoopTrans];

  // Snoop lookup on the registered table; at most one entry can match.
  // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
  always_comb begin
    hit_vec   = '0;
    hit_cnt   = '0;
    all_valid = 1'b1;
    for (int i = 0; i < MaxSnoopTrans; i++) begin
      all_valid = all_valid & tbl_q[i].valid;
      if (tbl_q[i].valid && tbl_q[i].idx == cm_snoop_addr_i) begin
        hit_vec[i] = 1'b1;
        hit_cnt    = hit_cnt | tbl_q[i].cnt;
      end
    end
  end

  assign hit              = |hit_vec;
  assign hit_block        = Serialize ? hit : (hit && hit_cnt == CntW'(MaxRespTrans));
  assign cm_snoop_stall_o = cm_snoop_valid_i & (hit_block | (~hit & all_valid));
  assign fire             = cm_snoop_valid_i & cm_snoop_ready_i & ~cm_snoop_stall_o;

  // Lowest-index free entry as of the start of the cycle.
  always_comb begin
    free_sel = '0;
    for (int i = MaxSnoopTrans - 1; i >= 0; i--) begin
      if (!tbl_q[i].valid) begin
        free_sel    = '0;
        free_sel[i] = 1'b1;
      end
    end
  end

  // Per-entry decrement is the number of completing ports matching that line.
  always_comb begin
    logic port_hit;
    unmatched = 1'b0;
    for (int i = 0; i < MaxSnoopTrans; i++) dec[i] = '0;
    for (int p = 0; p < NoRespPorts; p++) begin
      port_hit = 1'b0;
      if (cm_x_req_i[p]) begin
        for (int i = 0; i < MaxSnoopTrans; i++) begin
          if (tbl_q[i].valid && tbl_q[i].idx == cm_x_addr_i[p*CmAddrWidth +: CmAddrWidth]) begin
            dec[i]   = dec[i] + DecW'(1);
            port_hit = 1'b1;
          end
        end
        if (!port_hit) unmatched = 1'b1;
      end
    end
  end

  // Net update per entry: cnt + inc - dec in a widened sum, clearing on zero or underflow.
  always_comb begin
    logic [SumW-1:0] sum;
    tbl_d    = tbl_q;
    over_dec = 1'b0;
    sum      = '0;
    for (int i = 0; i < MaxSnoopTrans; i++) begin
      if (fire && !hit && free_sel[i]) begin
        tbl_d[i].valid = 1'b1;
        tbl_d[i].idx   = cm_snoop_addr_i;
        tbl_d[i].cnt   = CntW'(1);
      end else if (tbl_q[i].valid) begin
        sum = SumW'(tbl_q[i].cnt) + SumW'(fire & hit_vec[i]);
        if (SumW'(dec[i]) >= sum) begin
          tbl_d[i].valid = 1'b0;
          tbl_d[i].cnt   = '0;
          if (SumW'(dec[i]) > sum) over_dec = 1'b1;
        end else begin
          tbl_d[i].cnt = CntW'(sum - SumW'(dec[i]));
        end
      end
    end
  end

  always_comb begin
    occ_d  = '0;
    full_d = 1'b1;
    for (int i = 0; i < MaxSnoopTrans; i++) begin
      occ_d  = occ_d + OccW'(tbl_d[i].valid);
      full_d = full_d & tbl_d[i].valid;
    end
    err_d = unmatched | over_dec;
  end

  // NOTE: the table is built from flops rather than RAM, so it is reset; valid bits must start clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q  <= '0;
      occ_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      tbl_q  <= tbl_d;
      occ_q  <= occ_d;
      full_q <= full_d;
      err_q  <= err_d;
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = full_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ace_ccu_conflict_table.sv
// Self-checking bench: a serialising table (dut_s) and a merge-mode table with MaxRespTrans=2 (dut_m).
module tb_ace_ccu_conflict_table;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_valid, s_ready, s_stall, s_full, s_err;
  logic [7:0]  s_addr;
  logic [3:0]  s_req, s_occ;
  logic [31:0] s_xaddr;
  logic        m_valid, m_ready, m_stall, m_full, m_err;
  logic [7:0]  m_addr;
  logic [3:0]  m_req, m_occ;
  logic [31:0] m_xaddr;

  ace_ccu_conflict_table #(.Serialize(1'b1), .MaxRespTrans(8)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .cm_snoop_valid_i(s_valid), .cm_snoop_ready_i(s_ready), .cm_snoop_addr_i(s_addr),
    .cm_snoop_stall_o(s_stall), .cm_x_req_i(s_req), .cm_x_addr_i(s_xaddr),
    .occupancy_o(s_occ), .full_o(s_full), .err_o(s_err)
  );

  ace_ccu_conflict_table #(.Serialize(1'b0), .MaxRespTrans(2)) dut_m (
    .clk_i(clk), .rst_ni(rst_n),
    .cm_snoop_valid_i(m_valid), .cm_snoop_ready_i(m_ready), .cm_snoop_addr_i(m_addr),
    .cm_snoop_stall_o(m_stall), .cm_x_req_i(m_req), .cm_x_addr_i(m_xaddr),
    .occupancy_o(m_occ), .full_o(m_full), .err_o(m_err)
  );

  typedef struct {
    int          m;
    logic        valid, ready;
    logic [7:0]  addr;
    logic [3:0]  req;
    logic [31:0] xaddr;
    logic        stall;
    logic [3:0]  occ;
    logic        full, err;
    string       name;
  } vec_t;

  typedef struct {
    int         m;
    logic [3:0] occ;
    logic       full, err;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xa(input logic [7:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input int m, input logic v, r, input logic [7:0] a,
                              input logic [3:0] req, input logic [31:0] x, input logic st,
                              input logic [3:0] occ, input logic full, err, input string name);
    vec_t t;
    t.m = m; t.valid = v; t.ready = r; t.addr = a; t.req = req; t.xaddr = x;
    t.stall = st; t.occ = occ; t.full = full; t.err = err; t.name = name;
    return t;
  endfunction

  task automatic idle();
    s_valid = 0; s_ready = 0; s_addr = '0; s_req = '0; s_xaddr = '0;
    m_valid = 0; m_ready = 0; m_addr = '0; m_req = '0; m_xaddr = '0;
  endtask

  // One cycle: drive at the negedge, check stall mid-cycle, check registered outputs after the edge.
  task automatic cyc(input vec_t v);
    exp_t e;
    idle();
    if (v.m == 0) begin
      s_valid = v.valid; s_ready = v.ready; s_addr = v.addr; s_req = v.req; s_xaddr = v.xaddr;
    end else begin
      m_valid = v.valid; m_ready = v.ready; m_addr = v.addr; m_req = v.req; m_xaddr = v.xaddr;
    end
    #1;
    check({v.name, "_stall"}, (v.m == 0) ? s_stall : m_stall, v.stall);
    sb.push_back('{v.m, v.occ, v.full, v.err, v.name});
    @(posedge clk); #1;
    e = sb.pop_front();
    check({e.name, "_occ"},  (e.m == 0) ? s_occ  : m_occ,  e.occ);
    check({e.name, "_full"}, (e.m == 0) ? s_full : m_full, e.full);
    check({e.name, "_err"},  (e.m == 0) ? s_err  : m_err,  e.err);
    @(negedge clk);
  endtask

  task automatic step(input int m, input logic v, r, input logic [7:0] a, input logic [3:0] req,
                      input logic [31:0] x, input logic st, input logic [3:0] occ,
                      input logic full, err, input string name);
    cyc(mk(m, v, r, a, req, x, st, occ, full, err, name));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    s_valid = 1; s_ready = 1; s_addr = 8'h12;
    #1;
    check("rst_stall_s", s_stall, 1'b0);
    check("rst_occ_s", s_occ, 4'd0);
    check("rst_full_s", s_full, 1'b0);
    check("rst_err_s", s_err, 1'b0);
    check("rst_occ_m", m_occ, 4'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Serialising table: allocate, hit-stall, retire-in-same-cycle, unmatched completion.
    vecs.push_back(mk(0, 1, 1, 8'h12, 4'b0000, 0, 0, 1, 0, 0, "s_alloc"));
    vecs.push_back(mk(0, 1, 1, 8'h12, 4'b0000, 0, 1, 1, 0, 0, "s_hit_stall"));
    vecs.push_back(mk(0, 1, 1, 8'h12, 4'b0001, xa(8'h12, 0, 0, 0), 1, 0, 0, 0, "s_retiring_hit"));
    vecs.push_back(mk(0, 1, 1, 8'h12, 4'b0000, 0, 0, 1, 0, 0, "s_realloc"));
    vecs.push_back(mk(0, 1, 0, 8'h34, 4'b0000, 0, 0, 1, 0, 0, "s_no_ready"));
    vecs.push_back(mk(0, 0, 0, 8'h12, 4'b0010, xa(0, 8'h12, 0, 0), 0, 0, 0, 0, "s_complete"));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0100, xa(0, 0, 8'h99, 0), 0, 0, 0, 1, "s_unmatched"));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'b0000, 0, 0, 0, 0, 0, "s_err_one_cycle"));
    // Merge table, MaxRespTrans=2: counter saturation, double retire, underflow, inc+dec together.
    vecs.push_back(mk(1, 1, 1, 8'h40, 4'b0000, 0, 0, 1, 0, 0, "m_alloc"));
    vecs.push_back(mk(1, 1, 1, 8'h40, 4'b0000, 0, 0, 1, 0, 0, "m_merge"));
    vecs.push_back(mk(1, 1, 1, 8'h40, 4'b0000, 0, 1, 1, 0, 0, "m_saturated"));
    vecs.push_back(mk(1, 1, 1, 8'h40, 4'b0001, xa(8'h40, 0, 0, 0), 1, 1, 0, 0, "m_sat_retire"));
    vecs.push_back(mk(1, 1, 1, 8'h40, 4'b0000, 0, 0, 1, 0, 0, "m_third_fires"));
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0101, xa(8'h40, 0, 8'h40, 0), 0, 0, 0, 0, "m_double_retire"));
    vecs.push_back(mk(1, 1, 1, 8'h55, 4'b0000, 0, 0, 1, 0, 0, "m_alloc55"));
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0011, xa(8'h55, 8'h55, 0, 0), 0, 0, 0, 1, "m_underflow"));
    vecs.push_back(mk(1, 1, 1, 8'h55, 4'b0000, 0, 0, 1, 0, 0, "m_realloc55"));
    vecs.push_back(mk(1, 1, 1, 8'h55, 4'b0001, xa(8'h55, 0, 0, 0), 0, 1, 0, 0, "m_inc_dec"));
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'b0001, xa(8'h55, 0, 0, 0), 0, 0, 0, 0, "m_final_retire"));

    foreach (vecs[i]) cyc(vecs[i]);

    // Fill the serialising table, then full / hit stalls and reuse of a freed entry.
    for (int i = 0; i < 8; i++)
      step(0, 1, 1, 8'h80 + 8'(i), 0, 0, 0, 4'(i + 1), i == 7, 0, $sformatf("fill%0d", i));
    step(0, 1, 1, 8'hA0, 0, 0, 1, 8, 1, 0, "full_new_stall");
    step(0, 1, 1, 8'h83, 0, 0, 1, 8, 1, 0, "full_hit_stall");
    step(0, 1, 1, 8'hA0, 4'b0001, xa(8'h83, 0, 0, 0), 1, 7, 0, 0, "full_free3");
    step(0, 1, 1, 8'hA0, 0, 0, 0, 8, 1, 0, "reuse_free");
    step(0, 1, 1, 8'hA0, 0, 0, 1, 8, 1, 0, "reuse_hit");
    step(0, 0, 0, 8'h00, 4'b0111, xa(8'h80, 8'h81, 8'h82, 0), 0, 5, 0, 0, "drain_to5");

    // Asynchronous reset mid-cycle with five entries live.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_occ", s_occ, 4'd0);
    check("async_rst_full", s_full, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1, 8'h84, 0, 0, 0, 1, 0, 0, "post_rst_snoop");
    step(0, 0, 0, 8'h00, 4'b0001, xa(8'h85, 0, 0, 0), 0, 1, 0, 1, "post_rst_stale_cpl");
    step(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, "post_rst_err_clear");

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
